// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: controller states and
// the one-hot result encoding carried on {gt, eq, lt}.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result flags packed as {gt, eq, lt}; exactly one bit is set in DONE.
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

    function automatic logic [2:0] slice_to_result(input logic slice_gt);
        return slice_gt ? RES_GT : RES_LT;
    endfunction

endpackage

// File: rtl/comparator_2bit.sv
// Two-bit unsigned magnitude comparator slice; purely combinational.
module comparator_2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       a_gt_b,
    output logic       a_eq_b,
    output logic       a_lt_b
);

    assign a_gt_b = (a > b);
    assign a_eq_b = (a == b);
    assign a_lt_b = (a < b);

endmodule

// File: rtl/cmp_serial_ctrl.sv
// Serial WIDTH-bit unsigned comparator: walks 2-bit slices MSB first through one
// shared comparator_2bit and stops at the first unequal slice.
module cmp_serial_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             busy
);

    localparam int NSL  = WIDTH / 2;
    localparam int PW   = (NSL > 1) ? $clog2(NSL) : 1;
    // Slice table is padded to a power of two so every ptr value indexes in range.
    localparam int NPAD = 1 << PW;

    generate
        if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("cmp_serial_ctrl: WIDTH must be even and >= 2");
        end
    endgenerate

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [PW-1:0]    ptr_reg;
    logic             start_ready_reg;
    logic             res_valid_reg;
    logic [2:0]       res_flags_reg;
    logic             busy_reg;

    logic [1:0] a_slice [NPAD];
    logic [1:0] b_slice [NPAD];
    logic [1:0] slice_a;
    logic [1:0] slice_b;
    logic       slice_gt;
    logic       slice_eq;
    logic       slice_lt;

    generate
        for (genvar gi = 0; gi < NPAD; gi++) begin : g_slice
            if (gi < NSL) begin : g_real
                assign a_slice[gi] = a_reg[2*gi+1 : 2*gi];
                assign b_slice[gi] = b_reg[2*gi+1 : 2*gi];
            end else begin : g_pad
                assign a_slice[gi] = 2'b00;
                assign b_slice[gi] = 2'b00;
            end
        end
    endgenerate

    assign slice_a = a_slice[ptr_reg];
    assign slice_b = b_slice[ptr_reg];

    comparator_2bit u_slice (
        .a      (slice_a),
        .b      (slice_b),
        .a_gt_b (slice_gt),
        .a_eq_b (slice_eq),
        .a_lt_b (slice_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            a_reg           <= '0;
            b_reg           <= '0;
            ptr_reg         <= '0;
            start_ready_reg <= 1'b0;
            res_valid_reg   <= 1'b0;
            res_flags_reg   <= RES_NONE;
            busy_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Ready comes up one edge after reset release and stays up in IDLE.
                    start_ready_reg <= 1'b1;
                    if (start_valid && start_ready_reg) begin
                        a_reg           <= a;
                        b_reg           <= b;
                        ptr_reg         <= PW'(NSL - 1);
                        start_ready_reg <= 1'b0;
                        busy_reg        <= 1'b1;
                        state_reg       <= RUN;
                    end
                end
                RUN: begin
                    if (!slice_eq) begin
                        res_flags_reg <= slice_to_result(slice_gt && !slice_lt);
                        res_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else if (ptr_reg == '0) begin
                        res_flags_reg <= RES_EQ;
                        res_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        ptr_reg <= ptr_reg - 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_reg   <= 1'b0;
                        res_flags_reg   <= RES_NONE;
                        busy_reg        <= 1'b0;
                        start_ready_reg <= 1'b1;
                        state_reg       <= IDLE;
                    end
                end
                default: begin
                    state_reg       <= IDLE;
                    start_ready_reg <= 1'b0;
                    res_valid_reg   <= 1'b0;
                    res_flags_reg   <= RES_NONE;
                    busy_reg        <= 1'b0;
                end
            endcase
        end
    end

    assign start_ready = start_ready_reg;
    assign res_valid   = res_valid_reg;
    assign gt          = res_flags_reg[2];
    assign eq          = res_flags_reg[1];
    assign lt          = res_flags_reg[0];
    assign busy        = busy_reg;

endmodule

// File: tb/tb_cmp_serial_ctrl.sv
// Scoreboard bench for cmp_serial_ctrl: instance 0 is WIDTH=8, instance 1 is WIDTH=4.
module tb_cmp_serial_ctrl;

    typedef struct {
        int         dut;
        logic [2:0] flags;
        int         k;
        int         acc;
    } exp_t;

    exp_t exp_q[$];

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0][7:0]  a_s;
    logic [1:0][7:0]  b_s;
    logic [1:0]       start_valid_s;
    logic [1:0]       start_ready_s;
    logic [1:0]       res_valid_s;
    logic [1:0]       res_ready_s;
    logic [1:0]       gt_s;
    logic [1:0]       eq_s;
    logic [1:0]       lt_s;
    logic [1:0]       busy_s;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rr_mode;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            localparam int W = (gi == 0) ? 8 : 4;
            cmp_serial_ctrl #(.WIDTH(W)) u_dut (
                .clk         (clk),
                .rst_n       (rst_n),
                .start_valid (start_valid_s[gi]),
                .start_ready (start_ready_s[gi]),
                .a           (a_s[gi][W-1:0]),
                .b           (b_s[gi][W-1:0]),
                .res_valid   (res_valid_s[gi]),
                .res_ready   (res_ready_s[gi]),
                .gt          (gt_s[gi]),
                .eq          (eq_s[gi]),
                .lt          (lt_s[gi]),
                .busy        (busy_s[gi])
            );
        end
    endgenerate

    task automatic chk(input string name, input int g, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s dut=%0d actual=%0h required=%0h t=%0t", name, g, act, req, $time);
        end
    endtask

    // Reference: slices examined = MSB-first position of the first differing pair.
    function automatic int model_k(input int w, input int av, input int bv);
        for (int i = w / 2 - 1; i >= 0; i--) begin
            if (((av >> (2 * i)) & 3) != ((bv >> (2 * i)) & 3)) return w / 2 - i;
        end
        return w / 2;
    endfunction

    function automatic logic [2:0] model_flags(input int av, input int bv);
        if (av > bv) return 3'b100;
        if (av == bv) return 3'b010;
        return 3'b001;
    endfunction

    task automatic count_cycles();
        forever begin
            @(posedge clk);
            cyc++;
        end
    endtask

    task automatic drive_res_ready();
        forever begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 2; g++) begin
                case (rr_mode)
                    0: res_ready_s[g] = 1'b0;
                    1: res_ready_s[g] = 1'b1;
                    2: res_ready_s[g] = 1'($urandom_range(0, 1));
                    default: ;
                endcase
            end
        end
    endtask

    task automatic monitor();
        bit         prev_v [2];
        bit         hs_prev[2];
        logic [2:0] held   [2];
        logic [2:0] fl;
        exp_t       e;
        for (int g = 0; g < 2; g++) begin
            prev_v[g] = 0; hs_prev[g] = 0; held[g] = 3'b000;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                fl = {gt_s[g], eq_s[g], lt_s[g]};
                if (!rst_n) begin
                    prev_v[g]  = 0;
                    hs_prev[g] = 0;
                end else begin
                    if (hs_prev[g]) chk("valid_drop_after_ack", g, int'(res_valid_s[g]), 0);
                    if (res_valid_s[g]) begin
                        chk("start_ready_low_in_done", g, int'(start_ready_s[g]), 0);
                        chk("busy_in_done", g, int'(busy_s[g]), 1);
                        if (!prev_v[g]) begin
                            if (exp_q.size() == 0) begin
                                chk("unexpected_result", g, 1, 0);
                            end else begin
                                e = exp_q.pop_front();
                                chk("result_owner", g, g, e.dut);
                                chk("flags", g, int'(fl), int'(e.flags));
                                chk("latency", g, cyc - e.acc, e.k);
                                chk("onehot", g, $countones(fl), 1);
                                held[g] = fl;
                            end
                        end else begin
                            chk("flags_held", g, int'(fl), int'(held[g]));
                        end
                    end else begin
                        chk("flags_zero_without_valid", g, int'(fl), 0);
                    end
                    hs_prev[g] = res_valid_s[g] && res_ready_s[g];
                    prev_v[g]  = res_valid_s[g];
                end
            end
        end
    endtask

    task automatic issue(input int g, input logic [7:0] av, input logic [7:0] bv,
                         input bit push, input logic [2:0] fl, input int k);
        int n;
        n = 0;
        @(negedge clk);
        a_s[g] = av;
        b_s[g] = bv;
        start_valid_s[g] = 1'b1;
        while (!start_ready_s[g] && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_budget", g, int'(start_ready_s[g]), 1);
        if (push && start_ready_s[g]) exp_q.push_back('{g, fl, k, cyc + 1});
        @(posedge clk);
        #1;
        start_valid_s[g] = 1'b0;
        a_s[g] = 8'($urandom);
        b_s[g] = 8'($urandom);
        $display("txn dut=%0d a=%02h b=%02h exp={gt,eq,lt}=%03b k=%0d push=%0d",
                 g, av, bv, fl, k, push);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || res_valid_s != 2'b00) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_budget", 0, int'(n < 500), 1);
    endtask

    task automatic chk_all_zero(input string name, input int g);
        chk({name, "_start_ready"}, g, int'(start_ready_s[g]), 0);
        chk({name, "_res_valid"}, g, int'(res_valid_s[g]), 0);
        chk({name, "_flags"}, g, int'({gt_s[g], eq_s[g], lt_s[g]}), 0);
        chk({name, "_busy"}, g, int'(busy_s[g]), 0);
    endtask

    initial begin
        logic [7:0] av;
        logic [7:0] bv;
        int n;
        rst_n         = 1'b0;
        a_s           = '0;
        b_s           = '0;
        start_valid_s = '0;
        res_ready_s   = '0;
        rr_mode       = 1;
        fork
            count_cycles();
            monitor();
            drive_res_ready();
            begin
                #2000000;
                $display("FAIL watchdog actual=timeout required=finish");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) chk_all_zero("reset", g);
        rst_n = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) chk("ready_before_first_edge", g, int'(start_ready_s[g]), 0);
        @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) chk("ready_after_first_edge", g, int'(start_ready_s[g]), 1);

        // Directed cases with hand-derived results and latencies.
        issue(0, 8'hA5, 8'hA5, 1, 3'b010, 4);
        drain();
        issue(0, 8'hC0, 8'h40, 1, 3'b100, 1);
        drain();
        issue(0, 8'h12, 8'h13, 1, 3'b001, 4);
        drain();

        // Consumer stalls in DONE; start_valid must be ignored meanwhile.
        rr_mode = 3;
        @(posedge clk);
        #1 res_ready_s[0] = 1'b0;
        issue(0, 8'hC3, 8'hC7, 1, 3'b001, 3);
        n = 0;
        while (!res_valid_s[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_result_seen", 0, int'(res_valid_s[0]), 1);
        repeat (5) begin
            @(posedge clk);
            #1;
            start_valid_s[0] = 1'b1;
            a_s[0] = 8'($urandom);
            b_s[0] = 8'($urandom);
            @(negedge clk);
            chk("stall_start_ready", 0, int'(start_ready_s[0]), 0);
            chk("stall_res_valid", 0, int'(res_valid_s[0]), 1);
            chk("stall_lt", 0, int'(lt_s[0]), 1);
        end
        @(posedge clk);
        #1;
        start_valid_s[0] = 1'b0;
        res_ready_s[0]   = 1'b1;
        @(posedge clk);
        #1;
        chk("release_res_valid", 0, int'(res_valid_s[0]), 0);
        chk("release_start_ready", 0, int'(start_ready_s[0]), 1);
        chk("release_busy", 0, int'(busy_s[0]), 0);
        rr_mode = 1;
        drain();

        // Abort in the second RUN cycle; no result may appear.
        issue(0, 8'h00, 8'h01, 0, 3'b001, 4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("abort", 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_valid", 0, int'(res_valid_s[0]), 0);
        end
        rst_n = 1'b1;
        issue(0, 8'hFF, 8'hFE, 1, 3'b100, 4);
        drain();

        // Random 8-bit operands against the reference model with random stalls.
        rr_mode = 2;
        repeat (60) begin
            av = 8'($urandom);
            case ($urandom_range(0, 3))
                0: bv = av;
                1, 2: bv = av ^ (8'd1 << $urandom_range(0, 7));
                default: bv = 8'($urandom);
            endcase
            issue(0, av, bv, 1, model_flags(int'(av), int'(bv)), model_k(8, int'(av), int'(bv)));
        end
        drain();

        // Exhaustive 4-bit instance.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                issue(1, 8'(x), 8'(y), 1, model_flags(x, y), model_k(4, x, y));
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
